// File: rtl/fft8_stage_sequencer.sv
// Sequencer and in-place sample buffer for an 8-point radix-2 DIT FFT built around one external butterfly.
// Samples land bit-reversed, one butterfly is issued per clock for 3 stages, and bins leave in natural order.
module fft8_stage_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [DATA_W-1:0] bfu_a_real,
    output logic [DATA_W-1:0] bfu_a_imag,
    output logic [DATA_W-1:0] bfu_b_real,
    output logic [DATA_W-1:0] bfu_b_imag,
    output logic [1:0]        bfu_sel_w,
    input  logic [DATA_W-1:0] bfu_x0_real,
    input  logic [DATA_W-1:0] bfu_x0_imag,
    input  logic [DATA_W-1:0] bfu_x1_real,
    input  logic [DATA_W-1:0] bfu_x1_imag,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [1:0]        stage_q;
    logic [1:0]        bfly_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem_re_q [8];
    logic [DATA_W-1:0] mem_im_q [8];

    logic [2:0]        top_idx;
    logic [2:0]        bot_idx;
    logic [1:0]        sel_w;
    logic              in_fire;
    logic              out_fire;
    logic              compute_en;
    logic              last_bfly;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Butterfly addressing: top has bit s clear, bot is top with bit s set, twiddle is pos << (2-s).
    always_comb begin
        top_idx = 3'd0;
        bot_idx = 3'd0;
        sel_w   = 2'd0;
        case (stage_q)
            2'd0: begin
                top_idx = {bfly_q, 1'b0};
                bot_idx = {bfly_q, 1'b1};
                sel_w   = 2'd0;
            end
            2'd1: begin
                top_idx = {bfly_q[1], 1'b0, bfly_q[0]};
                bot_idx = {bfly_q[1], 1'b1, bfly_q[0]};
                sel_w   = {bfly_q[0], 1'b0};
            end
            2'd2: begin
                top_idx = {1'b0, bfly_q};
                bot_idx = {1'b1, bfly_q};
                sel_w   = bfly_q;
            end
            default: begin
                top_idx = 3'd0;
                bot_idx = 3'd0;
                sel_w   = 2'd0;
            end
        endcase
    end

    assign in_fire    = in_valid && in_ready_q;
    assign out_fire   = out_valid_q && out_ready;
    assign compute_en = (state_q == COMPUTE);
    assign last_bfly  = (stage_q == 2'd2) && (bfly_q == 2'd3);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // done must coincide with the final handshake itself, so it is decoded rather than registered.
    assign done      = out_fire && (cnt_q == 3'd7);

    assign bfu_a_real = compute_en ? mem_re_q[top_idx] : '0;
    assign bfu_a_imag = compute_en ? mem_im_q[top_idx] : '0;
    assign bfu_b_real = compute_en ? mem_re_q[bot_idx] : '0;
    assign bfu_b_imag = compute_en ? mem_im_q[bot_idx] : '0;
    assign bfu_sel_w  = compute_en ? sel_w : 2'd0;

    assign out_real = out_valid_q ? mem_re_q[cnt_q] : '0;
    assign out_imag = out_valid_q ? mem_im_q[cnt_q] : '0;

    // Frame controller; cnt_q doubles as load index n and unload index k and wraps back to 0 after each.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= 3'd0;
            stage_q     <= 2'd0;
            bfly_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q    <= COMPUTE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    bfly_q <= bfly_q + 2'd1;
                    if (bfly_q == 2'd3) begin
                        stage_q <= last_bfly ? 2'd0 : stage_q + 2'd1;
                    end
                    if (last_bfly) begin
                        state_q     <= UNLOAD;
                        out_valid_q <= 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q     <= LOAD;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= LOAD;
                    cnt_q       <= 3'd0;
                    stage_q     <= 2'd0;
                    bfly_q      <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Buffer needs no reset: every frame fully overwrites it before anything is read out.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re_q[bitrev3(cnt_q)] <= in_real;
            mem_im_q[bitrev3(cnt_q)] <= in_imag;
        end else if (compute_en) begin
            mem_re_q[top_idx] <= bfu_x0_real;
            mem_im_q[top_idx] <= bfu_x0_imag;
            mem_re_q[bot_idx] <= bfu_x1_real;
            mem_im_q[bot_idx] <= bfu_x1_imag;
        end
    end

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Directed bench for fft8_stage_sequencer with a behavioural butterfly unit wired around it.
// Frames are hand-computed DFTs: impulse, DC, shifted impulse, stalled output, and mid-compute reset.
module tb_fft8_stage_sequencer;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_real;
    logic signed [31:0] in_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_real;
    logic signed [31:0] out_imag;
    logic signed [31:0] bfu_a_real;
    logic signed [31:0] bfu_a_imag;
    logic signed [31:0] bfu_b_real;
    logic signed [31:0] bfu_b_imag;
    logic [1:0]         bfu_sel_w;
    logic signed [31:0] bfu_x0_real;
    logic signed [31:0] bfu_x0_imag;
    logic signed [31:0] bfu_x1_real;
    logic signed [31:0] bfu_x1_imag;
    logic               busy;
    logic               done;

    fft8_stage_sequencer #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .bfu_a_real  (bfu_a_real),
        .bfu_a_imag  (bfu_a_imag),
        .bfu_b_real  (bfu_b_real),
        .bfu_b_imag  (bfu_b_imag),
        .bfu_sel_w   (bfu_sel_w),
        .bfu_x0_real (bfu_x0_real),
        .bfu_x0_imag (bfu_x0_imag),
        .bfu_x1_real (bfu_x1_real),
        .bfu_x1_imag (bfu_x1_imag),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Butterfly unit: W1 = (1-j)/sqrt2, W3 = (-1-j)/sqrt2 with 1/sqrt2 as 23170/2^15, rounded half-up.
    function automatic logic signed [31:0] mulC(input logic signed [31:0] v);
        longint p;
        p = longint'(v) * 64'sd23170 + 64'sd16384;
        p = p >>> 15;
        return p[31:0];
    endfunction

    logic signed [31:0] wbRe;
    logic signed [31:0] wbIm;

    always_comb begin
        wbRe = 32'sd0;
        wbIm = 32'sd0;
        case (bfu_sel_w)
            2'd0: begin
                wbRe = bfu_b_real;
                wbIm = bfu_b_imag;
            end
            2'd1: begin
                wbRe = mulC(bfu_b_real + bfu_b_imag);
                wbIm = mulC(bfu_b_imag - bfu_b_real);
            end
            2'd2: begin
                wbRe = bfu_b_imag;
                wbIm = -bfu_b_real;
            end
            default: begin
                wbRe = mulC(bfu_b_imag - bfu_b_real);
                wbIm = -mulC(bfu_b_real + bfu_b_imag);
            end
        endcase
    end

    assign bfu_x0_real = bfu_a_real + wbRe;
    assign bfu_x0_imag = bfu_a_imag + wbIm;
    assign bfu_x1_real = bfu_a_real - wbRe;
    assign bfu_x1_imag = bfu_a_imag - wbIm;

    int checkCount = 0;
    int errorCount = 0;

    logic signed [31:0] stimRe [8];
    logic signed [31:0] stimIm [8];
    logic signed [31:0] expRe  [8];
    logic signed [31:0] expIm  [8];
    logic signed [31:0] gotRe  [8];
    logic signed [31:0] gotIm  [8];

    int firstAccept;
    int lastAccept;
    int firstValid;
    int lastOut;
    int doneCount;
    int binsGot;
    bit stallBad;
    bit stallSeen;
    bit doneBad;
    bit inReadyBad;
    bit busyBad;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_real  = stimRe[i];
            in_imag  = stimIm[i];
            for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
            if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
            if (i == 0) firstAccept = cyc;
            if (i == 7) lastAccept = cyc;
        end
    endtask

    task automatic collectOutput(input bit stress);
        logic signed [31:0] prevRe;
        logic signed [31:0] prevIm;
        bit havePrev;
        int k;
        k = 0;
        havePrev = 0;
        prevRe = 0;
        prevIm = 0;
        doneCount = 0;
        stallBad = 0;
        stallSeen = 0;
        doneBad = 0;
        inReadyBad = 0;
        busyBad = 0;
        firstValid = -1;
        lastOut = -1;
        for (int c = 0; c < 300 && k < 8; c++) begin
            @(negedge clk);
            if (!stress) in_valid = 1'b0;
            out_ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready) inReadyBad = 1;
            if (!busy) busyBad = 1;
            if (done) begin
                doneCount++;
                if (!(out_valid && out_ready && k == 7)) doneBad = 1;
            end
            if (out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                if (havePrev && (out_real !== prevRe || out_imag !== prevIm)) stallBad = 1;
                if (out_ready) begin
                    gotRe[k] = out_real;
                    gotIm[k] = out_imag;
                    if (k == 7) begin
                        lastOut = cyc;
                        in_valid = 1'b0;
                    end
                    k++;
                    havePrev = 0;
                end else begin
                    stallSeen = 1;
                    havePrev = 1;
                    prevRe = out_real;
                    prevIm = out_imag;
                end
            end
        end
        binsGot = k;
        checkOutput("bins_received", binsGot, 8);
        checkOutput("no_in_ready_while_busy", inReadyBad, 0);
        checkOutput("busy_while_busy", busyBad, 0);
        checkOutput("done_only_on_last", doneBad, 0);
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("latency", firstValid - lastAccept, 13);
        checkOutput("load_cycles", lastAccept - firstAccept, 7);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checkOutput("post_out_valid", out_valid, 0);
        checkOutput("post_in_ready", in_ready, 1);
        checkOutput("post_busy", busy, 0);
    endtask

    task automatic checkBins(input string name);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_bin%0d_re", name, k), gotRe[k], expRe[k]);
            checkOutput($sformatf("%s_bin%0d_im", name, k), gotIm[k], expIm[k]);
        end
    endtask

    task automatic setFrame(input int kind);
        for (int i = 0; i < 8; i++) begin
            stimIm[i] = 0;
            case (kind)
                0:       stimRe[i] = (i == 0) ? 1000 : 0;
                1:       stimRe[i] = 1000;
                default: stimRe[i] = (i == 1) ? 1000 : 0;
            endcase
        end
    endtask

    task automatic setExpect(input int kind);
        for (int k = 0; k < 8; k++) begin
            expIm[k] = 0;
            case (kind)
                0:       expRe[k] = 1000;
                default: expRe[k] = (k == 0) ? 8000 : 0;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_real = 0;
        in_imag = 0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_bfu_a_real", bfu_a_real, 0);
        checkOutput("rst_bfu_sel_w", bfu_sel_w, 0);
        checkOutput("rst_out_real", out_real, 0);
        rst = 1'b0;

        $display("[TB] impulse frame");
        setFrame(0);
        setExpect(0);
        applyStimulus();
        collectOutput(1'b0);
        checkOutput("impulse_unload_cycles", lastOut - firstValid, 7);
        checkBins("impulse");

        $display("[TB] dc frame");
        setFrame(1);
        setExpect(1);
        applyStimulus();
        collectOutput(1'b0);
        checkBins("dc");

        $display("[TB] shifted impulse frame");
        setFrame(2);
        expRe[0] = 1000;  expIm[0] = 0;
        expRe[1] = 707;   expIm[1] = -707;
        expRe[2] = 0;     expIm[2] = -1000;
        expRe[3] = -707;  expIm[3] = -707;
        expRe[4] = -1000; expIm[4] = 0;
        expRe[5] = -707;  expIm[5] = 707;
        expRe[6] = 0;     expIm[6] = 1000;
        expRe[7] = 707;   expIm[7] = 707;
        applyStimulus();
        collectOutput(1'b0);
        checkBins("shift");

        $display("[TB] stalled output with in_valid held");
        setFrame(1);
        setExpect(1);
        applyStimulus();
        collectOutput(1'b1);
        checkOutput("stall_data_stable", stallBad, 0);
        checkBins("stall");

        $display("[TB] reset during compute");
        setFrame(1);
        applyStimulus();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_sel_w", bfu_sel_w, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_bfu_a_real", bfu_a_real, 0);
        checkOutput("mid_rst_bfu_b_imag", bfu_b_imag, 0);
        checkOutput("mid_rst_bfu_sel_w", bfu_sel_w, 0);
        setFrame(0);
        setExpect(0);
        applyStimulus();
        collectOutput(1'b0);
        checkBins("after_rst");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
